// File: rtl/scan_peak_detect_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the sweep-synchronous peak detector:
//   state_t      - detector FSM states (IDLE, ARMED, SCAN)
//   SWEEP_CNT_W  - width of the completed half-sweep counter
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int SWEEP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SCAN  = 2'd2
    } state_t;

endpackage

// File: rtl/scan_peak_detect_if.sv
// -----------------------------------------------------------------------------
// scan_peak_detect_if
// Bundles the scanner-side inputs and result outputs of scan_peak_detect.
//   enable, ramp_value, trigger_low, trigger_hig, sig_in, threshold, timeout
//       : driven by the master (scanner / control side)
//   peak_val, peak_pos, peak_dir, peak_found, peak_valid, scan_timeout,
//   sweep_cnt
//       : driven by the slave (the detector)
// R must match the R parameter of the detector it is connected to.
// -----------------------------------------------------------------------------
interface scan_peak_detect_if #(
    parameter int R = 14
);
    import scan_pkg::*;

    logic                   enable;
    logic signed [R-1:0]    ramp_value;
    logic                   trigger_low;
    logic                   trigger_hig;
    logic signed [R-1:0]    sig_in;
    logic signed [R-1:0]    threshold;
    logic [31:0]            timeout;

    logic signed [R-1:0]    peak_val;
    logic signed [R-1:0]    peak_pos;
    logic                   peak_dir;
    logic                   peak_found;
    logic                   peak_valid;
    logic                   scan_timeout;
    logic [SWEEP_CNT_W-1:0] sweep_cnt;

    modport master (
        output enable, ramp_value, trigger_low, trigger_hig, sig_in,
               threshold, timeout,
        input  peak_val, peak_pos, peak_dir, peak_found, peak_valid,
               scan_timeout, sweep_cnt
    );

    modport slave (
        input  enable, ramp_value, trigger_low, trigger_hig, sig_in,
               threshold, timeout,
        output peak_val, peak_pos, peak_dir, peak_found, peak_valid,
               scan_timeout, sweep_cnt
    );

endinterface

// File: rtl/scan_peak_detect_tracker.sv
// -----------------------------------------------------------------------------
// peak_tracker
// Running maximum of a signed sample stream together with the position at
// which that maximum was first seen.
//   clk, rst   : clock, synchronous active-high reset
//   init       : load max/pos from this cycle's sample (segment start)
//   update     : fold this cycle's sample into the running maximum
//   sample     : signed sample value
//   pos_in     : position tag of the sample (ramp value)
//   max_out    : current maximum
//   pos_out    : position of the current maximum
// -----------------------------------------------------------------------------
module peak_tracker #(
    parameter int R = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic                update,
    input  logic signed [R-1:0] sample,
    input  logic signed [R-1:0] pos_in,
    output logic signed [R-1:0] max_out,
    output logic signed [R-1:0] pos_out
);

    logic signed [R-1:0] max_reg;
    logic signed [R-1:0] pos_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_reg <= '0;
            pos_reg <= '0;
        end else if (init) begin
            max_reg <= sample;
            pos_reg <= pos_in;
        end else if (update && (sample > max_reg)) begin
            // Strict compare: on equal values the earlier position is kept.
            max_reg <= sample;
            pos_reg <= pos_in;
        end
    end

    assign max_out = max_reg;
    assign pos_out = pos_reg;

endmodule

// File: rtl/scan_peak_detect.sv
// -----------------------------------------------------------------------------
// scan_peak_detect
// Sweep-synchronous peak detector. Between consecutive scanner triggers it
// tracks the maximum of sig_in and the ramp value where it occurred, and
// publishes one result per half-sweep.
//   clk, rst : clock, synchronous active-high reset
//   bus      : scan_peak_detect_if.slave
//              inputs  enable, ramp_value, trigger_low, trigger_hig, sig_in,
//                      threshold, timeout
//              outputs peak_val, peak_pos, peak_dir, peak_found,
//                      peak_valid (1-cycle), scan_timeout (1-cycle), sweep_cnt
// A trigger sample always opens the new segment; the closing segment never
// includes it. Simultaneous triggers are handled as trigger_low.
// -----------------------------------------------------------------------------
module scan_peak_detect
    import scan_pkg::*;
#(
    parameter int R = 14
) (
    input  logic               clk,
    input  logic               rst,
    scan_peak_detect_if.slave  bus
);

    state_t state_reg, state_next;

    logic                   trig;
    logic [31:0]            seg_cnt_reg;
    logic [31:0]            seg_cnt_inc;
    logic                   timeout_hit;

    // FSM output strobes
    logic                   trk_init;
    logic                   trk_update;
    logic                   seg_close;
    logic                   seg_expire;
    logic                   cnt_clear;
    logic                   cnt_step;

    logic                   dir_reg;
    logic signed [R-1:0]    trk_max;
    logic signed [R-1:0]    trk_pos;

    logic signed [R-1:0]    peak_val_reg;
    logic signed [R-1:0]    peak_pos_reg;
    logic                   peak_dir_reg;
    logic                   peak_found_reg;
    logic                   peak_valid_reg;
    logic                   scan_timeout_reg;
    logic [SWEEP_CNT_W-1:0] sweep_cnt_reg;

    assign trig        = bus.trigger_low | bus.trigger_hig;
    assign seg_cnt_inc = seg_cnt_reg + 32'd1;
    // The cycle whose increment brings the counter to timeout ends the segment.
    assign timeout_hit = (bus.timeout != 32'd0) && (seg_cnt_inc >= bus.timeout);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        if (!bus.enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = ARMED;
                ARMED:   if (trig) state_next = SCAN;
                SCAN: begin
                    if (trig)             state_next = SCAN;
                    else if (timeout_hit) state_next = ARMED;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- output (strobe) logic ----------------
    always_comb begin
        trk_init   = 1'b0;
        trk_update = 1'b0;
        seg_close  = 1'b0;
        seg_expire = 1'b0;
        cnt_clear  = 1'b0;
        cnt_step   = 1'b0;
        if (bus.enable) begin
            case (state_reg)
                ARMED: begin
                    if (trig) begin
                        trk_init  = 1'b1;
                        cnt_clear = 1'b1;
                    end
                end
                SCAN: begin
                    if (trig) begin
                        seg_close = 1'b1;
                        trk_init  = 1'b1;
                        cnt_clear = 1'b1;
                    end else if (timeout_hit) begin
                        seg_expire = 1'b1;
                    end else begin
                        trk_update = 1'b1;
                        cnt_step   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- segment counter and direction ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_cnt_reg <= '0;
            dir_reg     <= 1'b0;
        end else begin
            if (cnt_clear) begin
                seg_cnt_reg <= '0;
            end else if (cnt_step) begin
                seg_cnt_reg <= seg_cnt_inc;
            end
            if (trk_init) begin
                // trigger_low wins when both triggers coincide
                dir_reg <= bus.trigger_low;
            end
        end
    end

    peak_tracker #(
        .R (R)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .init    (trk_init),
        .update  (trk_update),
        .sample  (bus.sig_in),
        .pos_in  (bus.ramp_value),
        .max_out (trk_max),
        .pos_out (trk_pos)
    );

    // ---------------- result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_val_reg     <= '0;
            peak_pos_reg     <= '0;
            peak_dir_reg     <= 1'b0;
            peak_found_reg   <= 1'b0;
            peak_valid_reg   <= 1'b0;
            scan_timeout_reg <= 1'b0;
            sweep_cnt_reg    <= '0;
        end else begin
            peak_valid_reg   <= seg_close;
            scan_timeout_reg <= seg_expire;
            if (seg_close) begin
                peak_val_reg   <= trk_max;
                peak_pos_reg   <= trk_pos;
                peak_dir_reg   <= dir_reg;
                peak_found_reg <= (trk_max >= bus.threshold);
                sweep_cnt_reg  <= sweep_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.peak_val     = peak_val_reg;
    assign bus.peak_pos     = peak_pos_reg;
    assign bus.peak_dir     = peak_dir_reg;
    assign bus.peak_found   = peak_found_reg;
    assign bus.peak_valid   = peak_valid_reg;
    assign bus.scan_timeout = scan_timeout_reg;
    assign bus.sweep_cnt    = sweep_cnt_reg;

endmodule

// File: tb/tb_scan_peak_detect.sv
// -----------------------------------------------------------------------------
// tb_scan_peak_detect
// Self-checking bench for scan_peak_detect: directed scenarios with literal
// expectations followed by randomized stimulus, all outputs compared every
// cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_scan_peak_detect;

    localparam int R = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    scan_peak_detect_if #(.R(R)) bus ();

    scan_peak_detect #(.R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 armed, 2 scanning. The open segment is held as a plain
    // list of (sample, ramp) pairs; the result is found by scanning the list.
    int  m_mode = 0;
    int  q_sig[$];
    int  q_pos[$];
    bit  m_dir = 0;
    longint m_len = 0;
    int  e_val = 0, e_pos = 0, e_dir = 0, e_found = 0, e_valid = 0, e_to = 0, e_cnt = 0;

    task automatic seg_start(input bit tl, input int ramp, input int sig);
        q_sig.delete(); q_pos.delete();
        q_sig.push_back(sig); q_pos.push_back(ramp);
        m_dir  = tl;
        m_len  = 0;
        m_mode = 2;
    endtask

    task automatic seg_close(input int thr);
        int best;
        best = 0;
        for (int i = 1; i < q_sig.size(); i++)
            if (q_sig[i] > q_sig[best]) best = i;
        e_val   = q_sig[best];
        e_pos   = q_pos[best];
        e_dir   = m_dir;
        e_found = (e_val >= thr) ? 1 : 0;
        e_valid = 1;
        e_cnt   = (e_cnt + 1) % 65536;
    endtask

    task automatic model_step(input bit r, input bit en, input bit tl, input bit th,
                              input int ramp, input int sig, input int thr,
                              input longint to);
        e_valid = 0;
        e_to    = 0;
        if (r) begin
            m_mode = 0; q_sig.delete(); q_pos.delete();
            e_val = 0; e_pos = 0; e_dir = 0; e_found = 0; e_cnt = 0;
        end else if (!en) begin
            m_mode = 0; q_sig.delete(); q_pos.delete();
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (tl || th) seg_start(tl, ramp, sig);
                default: begin
                    if (tl || th) begin
                        seg_close(thr);
                        seg_start(tl, ramp, sig);
                    end else begin
                        q_sig.push_back(sig); q_pos.push_back(ramp);
                        m_len++;
                        if (to != 0 && m_len >= to) begin
                            e_to = 1;
                            m_mode = 1;
                            q_sig.delete(); q_pos.delete();
                        end
                    end
                end
            endcase
        end
    endtask

    // One clock: capture inputs, let the edge happen, advance the model.
    task automatic cyc();
        bit r, en, tl, th;
        int ramp, sig, thr;
        longint to;
        r    = rst;
        en   = bus.enable;
        tl   = bus.trigger_low;
        th   = bus.trigger_hig;
        ramp = int'($signed(bus.ramp_value));
        sig  = int'($signed(bus.sig_in));
        thr  = int'($signed(bus.threshold));
        to   = longint'(bus.timeout);
        @(posedge clk);
        model_step(r, en, tl, th, ramp, sig, thr, to);
        #1;
    endtask

    task automatic drive(input bit tl, input bit th, input int ramp, input int sig);
        bus.trigger_low = tl;
        bus.trigger_hig = th;
        bus.ramp_value  = ramp[R-1:0];
        bus.sig_in      = sig[R-1:0];
        cyc();
    endtask

    task automatic expect_result(input string tag, input int val, input int pos,
                                 input int dir, input int found, input int cnt);
        check({tag, ".peak_valid"}, longint'(bus.peak_valid), 1);
        check({tag, ".peak_val"},   longint'($signed(bus.peak_val)), val);
        check({tag, ".peak_pos"},   longint'($signed(bus.peak_pos)), pos);
        check({tag, ".peak_dir"},   longint'(bus.peak_dir), dir);
        check({tag, ".peak_found"}, longint'(bus.peak_found), found);
        check({tag, ".sweep_cnt"},  longint'(bus.sweep_cnt), cnt);
        $display("result %s: val=%0d pos=%0d dir=%0d found=%0d cnt=%0d", tag,
                 $signed(bus.peak_val), $signed(bus.peak_pos), bus.peak_dir,
                 bus.peak_found, bus.sweep_cnt);
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp.peak_valid",   longint'(bus.peak_valid), e_valid);
            check("cmp.scan_timeout", longint'(bus.scan_timeout), e_to);
            check("cmp.sweep_cnt",    longint'(bus.sweep_cnt), e_cnt);
            check("cmp.peak_val",     longint'($signed(bus.peak_val)), e_val);
            check("cmp.peak_pos",     longint'($signed(bus.peak_pos)), e_pos);
            check("cmp.peak_dir",     longint'(bus.peak_dir), e_dir);
            check("cmp.peak_found",   longint'(bus.peak_found), e_found);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        bus.enable      = 1'b0;
        bus.trigger_low = 1'b0;
        bus.trigger_hig = 1'b0;
        bus.ramp_value  = '0;
        bus.sig_in      = '0;
        bus.threshold   = 14'sd500;
        bus.timeout     = 32'd0;
        rst             = 1'b1;
        cyc();
        cyc();
        chk_on = 1'b1;

        // reset state
        check("reset.peak_val",     longint'($signed(bus.peak_val)), 0);
        check("reset.peak_pos",     longint'($signed(bus.peak_pos)), 0);
        check("reset.peak_valid",   longint'(bus.peak_valid), 0);
        check("reset.scan_timeout", longint'(bus.scan_timeout), 0);
        check("reset.sweep_cnt",    longint'(bus.sweep_cnt), 0);

        // basic sweep; the 2000 sample in ARMED must be ignored
        rst = 1'b0;
        bus.enable = 1'b1;
        drive(0, 0, 0, 5);
        drive(0, 0, 999, 2000);
        drive(1, 0, 0, 5);
        for (int k = 1; k <= 200; k++) drive(0, 0, k, (k == 123) ? 900 : 5);
        drive(0, 1, 201, 5);
        expect_result("basic", 900, 123, 1, 1, 1);

        // ties and threshold (down segment)
        drive(0, 0, 10, 400);
        drive(0, 0, 20, 400);
        for (int k = 0; k < 10; k++) drive(0, 0, 30 + k, -100);
        drive(1, 0, 0, -100);
        expect_result("ties", 400, 10, 0, 0, 2);

        // endpoint ownership
        drive(0, 0, 5, 100);
        drive(0, 0, 6, 20);
        drive(0, 1, 77, 700);
        expect_result("endpoint_up", 100, 5, 1, 0, 3);
        drive(0, 0, 70, 50);
        drive(1, 0, 0, -200);
        expect_result("endpoint_down", 700, 77, 0, 1, 4);

        // simultaneous triggers
        drive(0, 0, 3, 600);
        drive(1, 1, 9, -300);
        expect_result("both_trig", 600, 3, 1, 1, 5);
        drive(0, 0, 4, -250);
        drive(0, 1, 8, -280);
        expect_result("after_both", -250, 4, 1, 0, 6);

        // timeout
        bus.timeout = 32'd50;
        for (int i = 1; i <= 49; i++) drive(0, 0, i, 1);
        check("timeout.early", longint'(bus.scan_timeout), 0);
        drive(0, 0, 50, 1);
        check("timeout.pulse", longint'(bus.scan_timeout), 1);
        check("timeout.valid", longint'(bus.peak_valid), 0);
        check("timeout.cnt",   longint'(bus.sweep_cnt), 6);
        $display("timeout: scan_timeout=%0d sweep_cnt=%0d", bus.scan_timeout, bus.sweep_cnt);
        drive(0, 0, 0, 0);
        check("timeout.one_cycle", longint'(bus.scan_timeout), 0);
        drive(1, 0, 0, 10);
        drive(0, 0, 1, 30);
        drive(0, 1, 2, 20);
        expect_result("after_timeout", 30, 1, 1, 0, 7);
        bus.timeout = 32'd0;

        // abort via enable
        bus.enable = 1'b0;
        drive(0, 0, 0, 3000);
        bus.enable = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 0, 5, 100);
        check("abort.no_valid", longint'(bus.peak_valid), 0);
        drive(0, 0, 6, 200);
        drive(0, 1, 7, 0);
        expect_result("abort", 200, 6, 1, 0, 8);

        // reset mid-scan
        drive(0, 0, 1, 50);
        rst = 1'b1;
        drive(0, 0, 2, 60);
        check("rst.peak_val",   longint'($signed(bus.peak_val)), 0);
        check("rst.peak_pos",   longint'($signed(bus.peak_pos)), 0);
        check("rst.peak_dir",   longint'(bus.peak_dir), 0);
        check("rst.peak_found", longint'(bus.peak_found), 0);
        check("rst.sweep_cnt",  longint'(bus.sweep_cnt), 0);
        $display("reset mid-scan: sweep_cnt=%0d peak_val=%0d", bus.sweep_cnt, $signed(bus.peak_val));
        rst = 1'b0;

        // randomized phase
        for (int n = 0; n < 5000; n++) begin
            rst        = ($urandom_range(0, 799) == 0);
            bus.enable = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 199) == 0)
                bus.threshold = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 299) == 0)
                bus.timeout = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(2, 40));
            r = int'($urandom_range(0, 39));
            drive(r == 0 || r == 2, r == 1 || r == 2,
                  int'($urandom_range(0, 16383)) - 8192,
                  int'($urandom_range(0, 16383)) - 8192);
            if (bus.peak_valid)
                $display("rand result: val=%0d pos=%0d dir=%0d found=%0d cnt=%0d",
                         $signed(bus.peak_val), $signed(bus.peak_pos), bus.peak_dir,
                         bus.peak_found, bus.sweep_cnt);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_peak_detect.md
# scan_peak_detect

Sweep-synchronous peak detector on the receiving end of the ramp scanner. It samples a monitored signal against the scanner's ramp value. Between consecutive scan triggers it tracks the signal maximum and the ramp value where that maximum occurred, then reports one result per half-sweep. Its output feeds software readout and the lock-point selection that seeds the PID setpoint after a scan.

## Interface
- R, 14, width of the ramp value and monitored signal (signed)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  detector run; low aborts and returns to IDLE
- ramp_value  in  R  signed ramp output of the scanner, same cycle as triggers
- trigger_low  in  1  single-cycle pulse, ramp at low limit (start of up-slope)
- trigger_hig  in  1  single-cycle pulse, ramp at high limit (start of down-slope)
- sig_in  in  R  signed monitored signal (transmission/error)
- threshold  in  R  signed minimum peak value accepted as found
- timeout  in  32  max cycles per half-sweep; 0 disables timeout
- peak_val  out  R  signal maximum of last completed half-sweep
- peak_pos  out  R  ramp_value at that maximum
- peak_dir  out  1  1 = up-slope segment, 0 = down-slope
- peak_found  out  1  peak_val >= threshold for last result
- peak_valid  out  1  one-cycle pulse, new result on outputs
- scan_timeout  out  1  one-cycle pulse, half-sweep exceeded timeout
- sweep_cnt  out  16  completed half-sweeps, wraps at 2^16

## Operation
- States: IDLE, ARMED, SCAN. Reset and enable=0 force IDLE.
- IDLE -> ARMED when enable=1. ARMED waits for the first trigger; samples before it are discarded.
- Any trigger in ARMED -> SCAN. Tracker initialises with that cycle's sample: max=sig_in, pos=ramp_value. dir = 1 for trigger_low, 0 for trigger_hig.
- In SCAN, each cycle: if sig_in > max (strict, so the earliest of equal maxima wins), max=sig_in and pos=ramp_value.
- Trigger in SCAN closes the current segment. Result registers load max/pos/dir, peak_found = (max >= threshold), and sweep_cnt increments. The tracker restarts with the trigger-cycle sample as the first sample of the new segment. The endpoint belongs to the new segment.
- trigger_low and trigger_hig in the same cycle (low_lim == hig_lim) are treated as trigger_low: new dir=1.
- Segment counter cleared on every trigger and incremented each SCAN cycle. If timeout != 0 and counter reaches timeout: pulse scan_timeout, discard the tracker, go to ARMED. No peak_valid and no sweep_cnt change.
- enable falling mid-SCAN discards the open segment. Result registers keep their last values.
- All comparisons are signed R-bit. No arithmetic widening is needed.

## Timing
- Reset values: peak_val=0, peak_pos=0, peak_dir=0, peak_found=0, peak_valid=0, scan_timeout=0, sweep_cnt=0, state=IDLE.
- Inputs are sampled on the clk rising edge. There is no input pipeline; the scanner drives triggers and ramp_value aligned.
- peak_valid rises on the cycle after the closing trigger, with result outputs updated that same cycle. Outputs hold until the next result.
- Triggers on consecutive cycles are legal. A 1-cycle segment yields max = that single sample.
- scan_timeout is pulsed the cycle after the counter equals timeout.
- rst mid-SCAN returns to IDLE on the next edge, with all outputs at reset values.

## Structure
- Package scan_pkg: state enum (IDLE, ARMED, SCAN), SWEEP_CNT_W=16 constant.
- Sub-module peak_tracker (R): holds max/pos, with init and update strobes and the strict compare. Top level holds the FSM, timeout counter, result registers and sweep counter.

## Test plan
- Basic sweep: enable, trigger_low at t0, sig_in = 5 except 900 when ramp_value=123, trigger_hig later -> peak_valid 1 cycle after trigger_hig; peak_val=900, peak_pos=123, peak_dir=1, peak_found=1 (threshold=500), sweep_cnt=1.
- Ties and threshold: two samples = 400 at ramp 10 and 20, threshold=500 -> peak_pos=10, peak_found=0.
- Endpoint ownership: sig_in max (700) exactly on trigger_hig cycle -> excluded from up-segment result; next down-segment reports peak_val=700, peak_dir=0.
- Simultaneous triggers: both high the same cycle in SCAN -> one peak_valid, new dir=1, sweep_cnt +1.
- Timeout: timeout=50, no trigger for 50 SCAN cycles -> scan_timeout pulse, state ARMED, sweep_cnt unchanged; the next trigger restarts SCAN.
- Abort/reset: enable low mid-SCAN then high -> no peak_valid until second trigger after re-enable. rst mid-SCAN -> all outputs 0.
